// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch-stage program counter.
//   Holds the current fetch PC and advances it by 4 on each accepted fetch.
//   Trap, mret and branch/jump redirects are prioritised and applied at once.
//   Redirects arriving while clkEn is low are captured in a one-entry pending slot.
//   Misaligned targets can be rejected and reported.
//   A boot/run/halt state machine gates fetch requests.
// Ports:
//   clk, rstB                   clock, synchronous active-low reset
//   clkEn                       global enable; low freezes all but pending capture
//   stall                       blocks sequential advance only
//   fetch_ready                 imem accepts pc_out this cycle
//   halt_req                    level request to stop fetching
//   trap_en/trap_vec            highest-priority redirect
//   mret_en/mepc                middle-priority redirect
//   condEn/next_pc_cond         branch/jump redirect
//   pc_out, pc_valid            fetch request toward imem
//   halted                      unit is in HALT
//   misalign_err/misalign_addr  one-cycle reject pulse and held offending target
module pc_unit #(
  parameter int unsigned         XLEN        = 32,
  parameter logic [XLEN-1:0]     RESET_VEC   = '0,
  parameter bit                  ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic            clkEn,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            halt_req,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret_en,
  input  logic [XLEN-1:0] mepc,
  input  logic            condEn,
  input  logic [XLEN-1:0] next_pc_cond,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Redirect priority codes; larger value wins.
  localparam logic [1:0] PRIO_COND = 2'd0;
  localparam logic [1:0] PRIO_MRET = 2'd1;
  localparam logic [1:0] PRIO_TRAP = 2'd2;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_prio_q, pend_prio_d;
  logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;

  logic              new_red;
  logic [1:0]        new_prio;
  logic [XLEN-1:0]   new_tgt;
  logic              red_act;
  logic [XLEN-1:0]   sel_tgt;
  logic              bad_tgt;
  logic              adv;

  // Priority select among the incoming redirect pulses.
  always_comb begin
    new_red  = trap_en | mret_en | condEn;
    new_prio = PRIO_COND;
    new_tgt  = next_pc_cond;
    if (trap_en) begin
      new_prio = PRIO_TRAP;
      new_tgt  = trap_vec;
    end else if (mret_en) begin
      new_prio = PRIO_MRET;
      new_tgt  = mepc;
    end
  end

  // Next-state, PC and pending-slot logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    err_d        = err_q;
    addr_d       = addr_q;
    pend_valid_d = pend_valid_q;
    pend_prio_d  = pend_prio_q;
    pend_tgt_d   = pend_tgt_q;

    // A fresh redirect overrides the pending one in the same cycle.
    red_act = new_red | pend_valid_q;
    sel_tgt = new_red ? new_tgt : pend_tgt_q;
    bad_tgt = ALIGN_CHECK && red_act && (sel_tgt[1:0] != 2'b00);
    adv     = fetch_ready & ~stall;

    if (!clkEn) begin
      // Frozen: only capture, never letting a lower priority replace a higher one.
      if (new_red && (!pend_valid_q || (new_prio >= pend_prio_q))) begin
        pend_valid_d = 1'b1;
        pend_prio_d  = new_prio;
        pend_tgt_d   = new_tgt;
      end
    end else begin
      pend_valid_d = 1'b0;
      err_d        = 1'b0;

      unique case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
          if (red_act && !bad_tgt) pc_d = sel_tgt;
        end
        ST_RUN: begin
          if (red_act) begin
            if (!bad_tgt) pc_d = sel_tgt;
            if (halt_req) state_d = ST_HALT;
          end else if (adv) begin
            // A halt request consumes the handshake cycle without advancing.
            if (halt_req) state_d = ST_HALT;
            else          pc_d    = pc_q + XLEN'(4);
          end
        end
        ST_HALT: begin
          if (red_act && !bad_tgt) pc_d = sel_tgt;
          if (!halt_req) state_d = ST_RUN;
        end
        default: state_d = ST_BOOT;
      endcase

      if (bad_tgt) begin
        err_d  = 1'b1;
        addr_d = sel_tgt;
      end

      valid_d  = (state_d == ST_RUN);
      halted_d = (state_d == ST_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VEC;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_prio_q  <= PRIO_COND;
      pend_tgt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      pend_valid_q <= pend_valid_d;
      pend_prio_q  <= pend_prio_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc_valid      = valid_q;
  assign halted        = halted_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RV32I fetch stage.
- Generalises the basic PC register with:
  - configurable width and reset vector
  - prioritised redirect sources (trap, mret, branch/jump)
  - a valid/ready handshake toward instruction memory
  - one-entry capture of redirects arriving while the clock enable is low
  - target-misalignment detection
  - a boot/run/halt state machine
- Sits between the execute/CSR stages (redirect sources) and the imem fetch port.

Parameters:
- XLEN, 32, PC and target width in bits (>=8).
- RESET_VEC, 0, PC value loaded on reset (XLEN bits, must be 4-byte aligned).
- ALIGN_CHECK, 1, 1 enables misaligned-target detection; 0 loads targets unchecked.

Ports:
- clk  in  1  clock
- rstB  in  1  synchronous active-low reset
- clkEn  in  1  global clock enable; 0 freezes all state except pending-redirect capture
- stall  in  1  pipeline stall; blocks sequential advance only
- fetch_ready  in  1  imem accepts current pc_out
- halt_req  in  1  level request to stop fetching
- trap_en  in  1  trap redirect pulse
- trap_vec  in  XLEN  trap target
- mret_en  in  1  return-from-trap redirect pulse
- mepc  in  XLEN  mret target
- condEn  in  1  branch/jump redirect pulse
- next_pc_cond  in  XLEN  branch/jump target
- pc_out  out  XLEN  current fetch PC
- pc_valid  out  1  pc_out is a valid fetch request
- halted  out  1  unit is in HALT
- misalign_err  out  1  one-cycle pulse: rejected misaligned target
- misalign_addr  out  XLEN  offending target, held until next error

Behaviour:
- Reset (rstB=0 at posedge, overrides everything):
  - pc_out=RESET_VEC, pc_valid=0, halted=0, misalign_err=0, misalign_addr=0
  - pending redirect cleared; state=BOOT
- States:
  - BOOT: pc_valid=0. Next cycle with clkEn=1 -> RUN.
  - RUN: pc_valid=1. Moves to HALT at a posedge with clkEn=1 and halt_req=1, but only when the current request has either completed its handshake or no request is outstanding that cycle, i.e. (fetch_ready & !stall) or a redirect applies. Once halt_req is seen, the same posedge does not advance further.
  - HALT: pc_valid=0, halted=1. Returns to RUN at the first clkEn=1 posedge with halt_req=0.
- Redirect priority: trap_en > mret_en > condEn.
  - Selected target = trap_vec, mepc or next_pc_cond respectively.
- clkEn=1, redirect present (any state except BOOT):
  - pc_out <= selected target at the next posedge, independent of stall and fetch_ready.
  - In HALT the PC updates but the state stays HALT.
  - A redirect in BOOT is applied and the state goes to RUN.
- clkEn=1, no new redirect, pending valid:
  - pending target is applied as above, then pending is cleared.
  - A new redirect in the same cycle wins and also clears pending.
- clkEn=1, no redirect, RUN, fetch_ready=1, stall=0:
  - pc_out <= pc_out + 4, modulo 2^XLEN; wraps from max-3 to 0.
- Otherwise pc_out holds.
- clkEn=0:
  - pc_out, state and outputs hold.
  - Any redirect pulse is captured into the pending register; a higher-or-equal priority capture overwrites a lower one, and a lower one never overwrites a higher one.
- Misalignment (ALIGN_CHECK=1): applies to the selected target when target[1:0]!=0.
  - PC is not loaded; pending is cleared; pc_out holds; no sequential advance that cycle.
  - At the next posedge: misalign_err=1 for exactly one cycle and misalign_addr=target.
  - The trap redirect is itself checked. trap_vec is expected aligned; a misaligned trap_vec is still rejected and flagged.
- ALIGN_CHECK=0: targets are loaded verbatim; sequential adds +4 to whatever is present.
- Reset mid-operation discards pending redirects, halt state and the error flag.

Test Plan:
- Reset/boot: rstB low 2 cycles, RESET_VEC=0x100, fetch_ready=1 -> cycle 0 after reset pc_out=0x100, pc_valid=0; then valid=1, pc 0x100, 0x104, 0x108 on successive cycles.
- Handshake/stall: fetch_ready toggled 1,0,1 and stall=1 for one cycle -> PC advances only on cycles with fetch_ready=1 & stall=0; branch condEn=1, target 0x200 during stall -> pc_out=0x200 next cycle.
- Priority: trap_en, mret_en and condEn in the same cycle (targets 0x80, 0x300, 0x400) -> pc_out=0x80; mret+cond only -> 0x300.
- Pending capture: clkEn=0, condEn pulse 0x400, then trap pulse 0x80, then condEn 0x500 -> on clkEn=1 pc_out=0x80; repeat with only condEn 0x400 captured and new condEn 0x600 at enable -> 0x600.
- Misalign: condEn with target 0x202 at pc 0x10 -> pc_out stays 0x10, misalign_err high one cycle, misalign_addr=0x202; repeat with ALIGN_CHECK=0 -> pc_out=0x202, no error.
- Halt/wrap: start at pc 0xFFFFFFFC, halt_req=1 after one fetch -> pc_out=0x0, halted=1, pc_valid=0; condEn 0x40 while halted -> pc_out=0x40, still halted; halt_req=0 -> RUN, pc_valid=1 at 0x40.
